// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows stage with valid/ready flow control.
// The byte permutation is combinational ahead of stage 0; later stages are plain registers.
module shift_rows_pipe #(
  parameter int unsigned NB          = 4,
  parameter int unsigned PIPE        = 1,
  parameter bit          SUPPORT_INV = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_inv,
  output logic [32*NB-1:0]  out_data,
  output logic              busy
);

  localparam int unsigned W = 32 * NB;

  // Reject unsupported geometries at elaboration time.
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
    $error("shift_rows_pipe: PIPE must be in 1..4");
  end

  logic [W-1:0]    w_fwd;
  logic [W-1:0]    w_perm;
  logic            w_inv_bit;
  logic            w_accept;
  logic [PIPE-1:0] w_adv;

  logic [PIPE-1:0] r_vld;
  logic [PIPE-1:0] r_inv;
  logic [W-1:0]    r_data [PIPE];

  // Forward row rotation: out[r][c] = in[r][(c + sh(r)) mod NB].
  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int SH = (NB == 8 && r >= 2) ? r + 1 : r;
    for (genvar c = 0; c < int'(NB); c++) begin : g_col
      localparam int FC = (c + SH) % int'(NB);
      assign w_fwd[W-1-8*(r+4*c) -: 8] = in_data[W-1-8*(r+4*FC) -: 8];
    end
  end

  // Optional inverse rotation and per-beat direction select.
  if (SUPPORT_INV) begin : g_inv
    logic [W-1:0] w_inv;
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SH = (NB == 8 && r >= 2) ? r + 1 : r;
      for (genvar c = 0; c < int'(NB); c++) begin : g_col
        localparam int IC = (c + int'(NB) - SH) % int'(NB);
        assign w_inv[W-1-8*(r+4*c) -: 8] = in_data[W-1-8*(r+4*IC) -: 8];
      end
    end
    assign w_perm    = in_inv ? w_inv : w_fwd;
    assign w_inv_bit = in_inv;
  end else begin : g_no_inv
    logic w_unused_inv;
    assign w_unused_inv = in_inv;
    assign w_perm       = w_fwd;
    assign w_inv_bit    = 1'b0;
  end

  // Stage k may advance when it is empty or every stage downstream of it can move.
  for (genvar k = 0; k < int'(PIPE); k++) begin : g_adv
    assign w_adv[k] = out_ready | ~(&r_vld[PIPE-1:k]);
  end

  assign in_ready = w_adv[0] & ~flush & rst_n;
  assign w_accept = in_valid & in_ready;

  // Stage registers: valids move on advance, payload only when a valid beat moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_inv <= '0;
      for (int unsigned k = 0; k < PIPE; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      if (flush) begin
        r_vld <= '0;
      end else begin
        if (w_adv[0]) begin
          r_vld[0] <= in_valid;
        end
        for (int unsigned k = 1; k < PIPE; k++) begin
          if (w_adv[k]) begin
            r_vld[k] <= r_vld[k-1];
          end
        end
      end
      if (w_accept) begin
        r_inv[0]  <= w_inv_bit;
        r_data[0] <= w_perm;
      end
      for (int unsigned k = 1; k < PIPE; k++) begin
        if (w_adv[k] && r_vld[k-1]) begin
          r_inv[k]  <= r_inv[k-1];
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  assign out_valid = r_vld[PIPE-1];
  assign out_inv   = r_inv[PIPE-1];
  assign out_data  = r_data[PIPE-1];
  assign busy      = |r_vld;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed and randomized checks for shift_rows_pipe (NB=4/PIPE=3 main instance, NB=8/PIPE=1 side instance).
module tb_shift_rows_pipe;

  localparam int unsigned P = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, out_inv, busy;
  logic [127:0] out_data;

  logic         v8 = 1'b0, inv8 = 1'b0, rdy8 = 1'b0;
  logic [255:0] d8 = '0;
  logic         ir8, ov8, oi8, busy8;
  logic [255:0] od8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .PIPE(P), .SUPPORT_INV(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv), .out_data(out_data),
    .busy(busy)
  );

  shift_rows_pipe #(.NB(8), .PIPE(1), .SUPPORT_INV(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(v8), .in_ready(ir8), .in_inv(inv8), .in_data(d8),
    .out_valid(ov8), .out_ready(rdy8), .out_inv(oi8), .out_data(od8),
    .busy(busy8)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ShiftRows for a 128-bit state, row r rotated by r columns.
  function automatic logic [127:0] model4(input logic inv, input logic [127:0] d);
    logic [127:0] o;
    int src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = d[127-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  // One isolated beat through the main instance with out_ready held high.
  task automatic send4(input logic inv, input logic [127:0] d,
                       output logic [127:0] od, output logic oi, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_inv = inv; in_data = d; out_ready = 1'b1;
    #1 chk("send_in_ready", 256'(in_ready), 256'(1));
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
    end
    od = out_data;
    oi = out_inv;
  endtask

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] od, bb [8], ff [5];
    logic [255:0] s8, fwd8;
    logic         oi, held_v, held_i, pend;
    logic [127:0] held_d;
    logic [128:0] q [$];
    logic [128:0] ex;
    int           lat, cyc, sent, recv, seen;

    vecs[0] = '{1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
    vecs[1] = '{1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[2] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00050a0f04090e03080d02070c01060b};
    vecs[3] = '{1'b1, 128'h00050a0f04090e03080d02070c01060b, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[4] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h000d0a0704010e0b0805020f0c090603};
    vecs[5] = '{1'b0, 128'h0, 128'h0};

    // Reset state
    #12;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_inv",   256'(out_inv),   256'(0));
    chk("rst_out_data",  256'(out_data),  256'(0));
    chk("rst_busy",      256'(busy),      256'(0));
    chk("rst_in_ready",  256'(in_ready),  256'(0));
    chk("rst_nb8_valid", 256'(ov8),       256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed vectors
    for (int i = 0; i < 6; i++) begin
      send4(vecs[i].inv, vecs[i].din, od, oi, lat);
      chk("vec_latency", 256'(lat), 256'(P));
      chk("vec_data",    256'(od),  256'(vecs[i].dout));
      chk("vec_inv",     256'(oi),  256'(vecs[i].inv));
    end

    // NB=8 forward then inverse round trip
    s8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    @(negedge clk);
    v8 = 1'b1; inv8 = 1'b0; d8 = s8; rdy8 = 1'b1;
    @(negedge clk);
    chk("nb8_valid",  256'(ov8),         256'(1));
    chk("nb8_col0",   256'(od8[255:224]), 256'(32'h00050e13));
    chk("nb8_inv0",   256'(oi8),         256'(0));
    fwd8 = od8;
    inv8 = 1'b1; d8 = fwd8;
    @(negedge clk);
    v8 = 1'b0;
    chk("nb8_round",  od8,               s8);
    chk("nb8_inv1",   256'(oi8),         256'(1));
    @(negedge clk);

    // Back-to-back beats: one per cycle, fixed latency
    for (int j = 0; j < 8; j++) bb[j] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 8 + int'(P); i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (i < 8);
      if (i < 8) begin
        in_data = bb[i];
        in_inv  = 1'(i % 2);
      end
      #1;
      if (i < 8) chk("b2b_in_ready", 256'(in_ready), 256'(1));
      if (i >= int'(P)) begin
        chk("b2b_valid", 256'(out_valid), 256'(1));
        chk("b2b_data",  256'({out_inv, out_data}),
            256'({1'((i - int'(P)) % 2), model4(1'((i - int'(P)) % 2), bb[i - int'(P)])}));
      end
    end

    // Fill with out_ready low, stall, drain+fill, then flush
    for (int j = 0; j < 5; j++) ff[j] = {$urandom, $urandom, $urandom, $urandom};
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_data = ff[j];
      #1 chk("fill_in_ready", 256'(in_ready), 256'(1));
    end
    @(negedge clk);
    in_data = ff[3];
    #1;
    chk("full_in_ready", 256'(in_ready), 256'(0));
    chk("full_busy",     256'(busy),     256'(1));
    chk("full_head",     256'(out_data), 256'(model4(1'b0, ff[0])));
    @(negedge clk);
    #1;
    chk("stall_head",     256'({out_valid, out_data}), 256'({1'b1, model4(1'b0, ff[0])}));
    chk("stall_in_ready", 256'(in_ready), 256'(0));
    out_ready = 1'b1;
    #1 chk("drainfill_in_ready", 256'(in_ready), 256'(1));
    @(negedge clk);
    chk("drain_next", 256'(out_data), 256'(model4(1'b0, ff[1])));
    out_ready = 1'b0; flush = 1'b1; in_data = ff[4];
    #1 chk("flush_in_ready", 256'(in_ready), 256'(0));
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy",  256'(busy),      256'(0));
    chk("flush_valid", 256'(out_valid), 256'(0));
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_stale", 256'(seen), 256'(0));

    // Random traffic with backpressure against a scoreboard
    cyc = 0; sent = 0; recv = 0; held_v = 1'b0; pend = 1'b0;
    held_d = '0; held_i = 1'b0;
    while (recv < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 9) < 3);
      if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
        pend    = 1'b1;
        in_inv  = 1'($urandom);
        in_data = {$urandom, $urandom, $urandom, $urandom};
      end
      in_valid = pend;
      #1;
      if (held_v) chk("rand_stall_hold", 256'({out_valid, out_inv, out_data}),
                      256'({1'b1, held_i, held_d}));
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_i = out_inv;
      if (in_valid && in_ready) begin
        q.push_back({in_inv, model4(in_inv, in_data)});
        sent++;
        pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious", 256'(1), 256'(0));
        end else begin
          ex = q.pop_front();
          chk("rand_beat", 256'({out_inv, out_data}), 256'(ex));
        end
        recv++;
      end
    end
    chk("rand_count", 256'(recv), 256'(1000));
    @(negedge clk);
    in_valid = 1'b0;

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_inv = 1'b0; in_data = ff[i];
    end
    #1 chk("pre_rst_valid", 256'(out_valid), 256'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid",    256'(out_valid), 256'(0));
    chk("arst_data",     256'(out_data),  256'(0));
    chk("arst_in_ready", 256'(in_ready),  256'(0));
    chk("arst_busy",     256'(busy),      256'(0));
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send4(1'b0, vecs[0].din, od, oi, lat);
    chk("post_rst_lat",  256'(lat), 256'(P));
    chk("post_rst_fwd",  256'(od),  256'(vecs[0].dout));
    send4(1'b1, od, od, oi, lat);
    chk("post_rst_round", 256'(od), 256'(vecs[0].din));
    chk("post_rst_inv",   256'(oi), 256'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
